// File: rtl/reg_file.sv
// Multi-ported register file: NREGS x WIDTH flops, two combinational read ports,
// one synchronous write port, optional hardwired r0 and optional write-to-read bypass.
module reg_file #(
    parameter int WIDTH    = 32,
    parameter int NREGS    = 32,
    parameter bit ZERO_REG = 1'b1,
    parameter bit BYPASS   = 1'b1,
    localparam int AW      = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    output logic             wr_err
);

    localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic             wr_err_q;
    logic             wr_err_d;
    logic             wa_in_range;
    logic             wr_en;

    function automatic logic addr_ok(input logic [AW-1:0] a);
        return ({1'b0, a} < NREGS_W);
    endfunction

    // A write is committed only for in-range addresses that are not the hardwired r0.
    always_comb begin
        wa_in_range = addr_ok(wa);
        wr_en       = we && wa_in_range && !(ZERO_REG && (wa == '0));
    end

    always_comb begin
        for (int unsigned i = 0; i < NREGS; i++) begin
            regs_d[i] = (wr_en && (wa == AW'(i))) ? wd : regs_q[i];
        end
        wr_err_d = we && !wa_in_range;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end

    // Bypass only forwards writes that will actually land, so r0 and bad addresses read 0.
    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        logic [WIDTH-1:0] val;
        val = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            if (ra == AW'(i)) begin
                val = regs_q[i];
            end
        end
        if (rst || !addr_ok(ra) || (ZERO_REG && (ra == '0))) begin
            val = '0;
        end else if (BYPASS && wr_en && (wa == ra)) begin
            val = wd;
        end
        return val;
    endfunction

    always_comb begin
        rd1 = read_port(ra1);
        rd2 = read_port(ra2);
    end

    assign wr_err = wr_err_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: two instances (default config, and NREGS=24 with
// no zero register and no bypass) share stimulus and are checked against a reference model.
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1_a, rd2_a, rd1_b, rd2_b;
    logic        err_a, err_b;

    reg_file #(.WIDTH(32), .NREGS(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_a), .rd2(rd2_a), .wr_err(err_a)
    );

    reg_file #(.WIDTH(32), .NREGS(24), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
        .clk(clk), .rst(rst), .we(we), .wa(wa), .wd(wd), .ra1(ra1), .ra2(ra2),
        .rd1(rd1_b), .rd2(rd2_b), .wr_err(err_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Reference model state and per-instance configuration
    logic [31:0] mem [2][64];
    logic        err_m [2];
    int          nregs [2] = '{32, 24};
    bit          zr [2]    = '{1'b1, 1'b0};
    bit          bp [2]    = '{1'b1, 1'b0};
    bit          reset_seen = 1'b0;

    function automatic logic [31:0] m_read(int k, logic [4:0] ra);
        if (rst) return 32'h0;
        if (int'(ra) >= nregs[k]) return 32'h0;
        if (zr[k] && ra == 5'd0) return 32'h0;
        if (bp[k] && we && wa == ra) return wd;
        return mem[k][ra];
    endfunction

    task automatic m_edge();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 64; i++) mem[k][i] = 32'h0;
                err_m[k] = 1'b0;
            end else begin
                err_m[k] = we && (int'(wa) >= nregs[k]);
                if (we && int'(wa) < nregs[k] && !(zr[k] && wa == 5'd0))
                    mem[k][wa] = wd;
            end
        end
        if (rst) reset_seen = 1'b1;
    endtask

    task automatic drive(input logic r, input logic w, input logic [4:0] a,
                         input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
        exp_t e;
        @(posedge clk);
        #1;
        m_edge();
        rst = r; we = w; wa = a; wd = d; ra1 = r1; ra2 = r2;
        if (reset_seen) begin
            for (int k = 0; k < 2; k++) begin
                e.inst = k;
                e.rd1  = m_read(k, r1);
                e.rd2  = m_read(k, r2);
                e.err  = err_m[k];
                q.push_back(e);
            end
        end
    endtask

    // Monitor: drains this cycle's expectations away from the active edge
    initial begin
        exp_t        e;
        logic [31:0] a1, a2;
        logic        ae;
        forever begin
            @(negedge clk);
            while (q.size() > 0) begin
                e  = q.pop_front();
                a1 = (e.inst == 0) ? rd1_a : rd1_b;
                a2 = (e.inst == 0) ? rd2_a : rd2_b;
                ae = (e.inst == 0) ? err_a : err_b;
                checks++;
                if (a1 !== e.rd1) begin
                    errors++;
                    $display("FAIL rd1 inst%0d t=%0t ra1=%0d: got %h expected %h", e.inst, $time, ra1, a1, e.rd1);
                end
                checks++;
                if (a2 !== e.rd2) begin
                    errors++;
                    $display("FAIL rd2 inst%0d t=%0t ra2=%0d: got %h expected %h", e.inst, $time, ra2, a2, e.rd2);
                end
                checks++;
                if (ae !== e.err) begin
                    errors++;
                    $display("FAIL wr_err inst%0d t=%0t: got %b expected %b", e.inst, $time, ae, e.err);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic        r, w;
        logic [4:0]  a, r1, r2;
        logic [31:0] d;
        rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;

        drive(1, 0, 0, 32'h0, 0, 0);
        drive(1, 0, 0, 32'h0, 5, 7);
        // Reset wins over a simultaneous write
        drive(0, 1, 5, 32'hDEADBEEF, 5, 7);
        drive(1, 1, 7, 32'h0000_1234, 5, 7);
        drive(0, 0, 0, 32'h0, 5, 7);
        // Both ports, same address on both
        drive(0, 1, 1, 32'h0000_0011, 1, 31);
        drive(0, 1, 31, 32'hFFFF_FFFF, 1, 31);
        drive(0, 0, 0, 32'h0, 1, 31);
        drive(0, 0, 0, 32'h0, 31, 31);
        // r0 handling
        drive(0, 1, 0, 32'hA5A5_A5A5, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);
        // Bypass vs. storage-only visibility
        drive(0, 1, 3, 32'h1, 3, 3);
        drive(0, 1, 3, 32'h2, 3, 3);
        drive(0, 0, 0, 32'h0, 3, 3);
        // Out-of-range write for the 24-entry instance, then error clears
        drive(0, 1, 28, 32'h55, 28, 28);
        drive(0, 0, 0, 32'h0, 28, 0);
        drive(0, 0, 0, 32'h0, 28, 0);
        drive(0, 1, 28, 32'h66, 0, 0);
        drive(0, 1, 29, 32'h77, 0, 0);
        drive(0, 0, 0, 32'h0, 0, 0);
        for (int i = 0; i < 32; i++) begin
            r1 = 5'(i);
            r2 = 5'(31 - i);
            drive(0, 0, 0, 32'h0, r1, r2);
        end
        // Back-to-back writes with ra2 held
        drive(0, 1, 2, 32'hA, 0, 2);
        drive(0, 1, 2, 32'hB, 0, 2);
        drive(0, 1, 4, 32'hC, 4, 2);
        drive(0, 0, 0, 32'h0, 4, 2);

        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 79) == 0);
            w  = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            d  = $urandom;
            r1 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 2) == 0) ? a : 5'($urandom_range(0, 31));
            drive(r, w, a, d, r1, r2);
        end
        drive(0, 0, 0, 32'h0, 0, 0);

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
# reg_file

Parametrised multi-ported register file for the processor datapath, built from the same clocked-register primitive as the program counter. It provides `NREGS` general-purpose registers of `WIDTH` bits, two combinational read ports and one synchronous write port. Register 0 is optionally hardwired to zero, and same-cycle write-to-read bypass is optional. It sits between instruction decode, which supplies the read addresses, and writeback, which supplies the write port.

## Interface

**Parameters**
- `WIDTH`, 32: bits per register.
- `NREGS`, 32: number of registers, 2..64, need not be a power of two.
- `AW`, `$clog2(NREGS)`: address width, derived, not overridden.
- `ZERO_REG`, 1: 1 means register 0 always reads 0 and ignores writes.
- `BYPASS`, 1: 1 means a read of the address being written this cycle returns `wd`.

**Ports**
- `clk`, in, 1: clock; all state updates occur on the rising edge.
- `rst`, in, 1: synchronous reset, active-high.
- `we`, in, 1: write enable.
- `wa`, in, AW: write address.
- `wd`, in, WIDTH: write data.
- `ra1`, in, AW: read address, port 1.
- `ra2`, in, AW: read address, port 2.
- `rd1`, out, WIDTH: read data, port 1 (combinational).
- `rd2`, out, WIDTH: read data, port 2 (combinational).
- `wr_err`, out, 1: registered flag, set for one cycle after a write to an out-of-range address.

## Operation

**Storage**
- `NREGS` × `WIDTH` flip-flops.
- No RAM inference is required.

**Write**
- At a rising edge with `rst=0`, `we=1` and `wa<NREGS`, `regs[wa] <= wd`.
- The write is ignored when `wa=0` and `ZERO_REG=1`.
- A write with `wa>=NREGS` changes no register. It sets `wr_err=1` for the following cycle only.

**Read**
- Each read port operates independently and combinationally:
  - `ra>=NREGS` → 0.
  - `ra=0` and `ZERO_REG=1` → 0.
  - `BYPASS=1`, `we=1`, `wa==ra`, and the write is not suppressed by the two rules above → `wd`.
  - Otherwise → `regs[ra]`.
- Both ports may read the same address; both return identical data.

**Reset**
- At a rising edge with `rst=1`, every register clears to 0 and `wr_err` clears to 0.
- Reset wins over a simultaneous write; the write is lost.
- While `rst=1`, `rd1` and `rd2` are forced to 0 and bypass is disabled.

**Reset mid-operation**
- Contents written before the reset edge are not recoverable.
- The first write accepted is the one at the first rising edge with `rst=0`.

## Timing

- Read latency is 0 cycles, purely combinational from `ra*`, `we`, `wa`, `wd` and storage.
- Write latency is 1 edge.
  - `BYPASS=1`: data is visible on the same cycle via bypass, and from storage after the edge.
  - `BYPASS=0`: data is visible only after the edge.
- `wr_err` is valid 1 cycle after the offending write and lasts exactly 1 cycle, unless another out-of-range write follows.
- Reset values, observable after the first reset edge:
  - all registers = 0;
  - `rd1` = `rd2` = 0;
  - `wr_err` = 0.
- Before the first reset edge, contents are undefined. Verification must not check reads before reset.
- There is no combinational path from `rst` to storage; the forcing of read outputs to 0 during reset is combinational.

## Test plan

- **Reset:**
  - Stimulus: write 0xDEADBEEF to r5, then pulse `rst` for 1 cycle together with `we=1`, `wa=7`, `wd=0x1234`.
  - Required: r5 and r7 both read 0; `wr_err=0`; `rd1`/`rd2`=0 while `rst=1`.
- **Write/read, both ports:**
  - Stimulus: write r1=0x00000011 and r31=0xFFFFFFFF, then `ra1=1`, `ra2=31`.
  - Required: `rd1=0x11`, `rd2=0xFFFFFFFF`. With `ra1=ra2=31`, both ports return 0xFFFFFFFF.
- **Zero register:**
  - Stimulus: `ZERO_REG=1`, `we=1`, `wa=0`, `wd=0xA5A5A5A5`; then read r0.
  - Required: 0 on both ports, including in the write cycle (no bypass for r0).
- **Bypass:**
  - Stimulus: r3 holds 0x1; same cycle `we=1`, `wa=3`, `wd=0x2`, `ra1=3`.
  - Required: `BYPASS=1` → `rd1=0x2` before the edge. `BYPASS=0` → `rd1=0x1` before the edge and 0x2 after.
- **Out of range:**
  - Stimulus: `NREGS=24` (AW=5), write `wa=28`, `wd=0x55`; then read `ra1=28`.
  - Required: `rd1=0`; `wr_err=1` for exactly the next cycle; registers 0..23 unchanged.
- **Back-to-back:**
  - Stimulus: writes r2=0xA, r2=0xB, r4=0xC on consecutive edges.
  - Required: after the third edge, r2=0xB and r4=0xC. With `ra2=2` held throughout and `BYPASS=1`, `rd2` reads 0xA, 0xB, 0xB in the three write cycles.
